// File: rtl/ctrl_iq_fsm.sv
// Multi-cycle controller: instruction-queue FIFO feeding a decode/sequencing FSM.
// Optional performance counters (retired_cnt_o, skip_cnt_o) enabled by CTRL_PERF_CNT_EN.
module ctrl_iq_fsm #(
  parameter int unsigned INSTR_W  = 32,
  parameter int unsigned IQ_DEPTH = 4,
  parameter int unsigned REG_AW   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] imem_data_i,
  input  logic               imem_valid_i,
  output logic               imem_ready_o,
  input  logic [3:0]         nzcv_i,
  output logic [INSTR_W-1:0] ir_o,
  output logic [REG_AW-1:0]  rd_o,
  output logic [REG_AW-1:0]  rn_o,
  output logic [REG_AW-1:0]  rm_o,
  output logic [23:0]        imm24_o,
  output logic [3:0]         alu_op_o,
  output logic               write_reg_o,
  output logic               write_pc_o,
  output logic [1:0]         pc_s_o,
  output logic               la_o,
  output logic               lb_o,
  output logic               lc_o,
  output logic               lf_o,
  output logic               und_ins_o,
`ifdef CTRL_PERF_CNT_EN
  output logic [31:0]        retired_cnt_o,
  output logic [31:0]        skip_cnt_o,
`endif
  output logic               busy_o
);

  localparam int unsigned PtrW = $clog2(IQ_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [2:0] {
    StIdle, StDecode, StRead, StExec, StWb, StBranch, StUnd
  } state_e;

  state_e             state_q;
  logic [INSTR_W-1:0] ir_q;
  logic               la_q, lb_q, lc_q, lf_q, write_reg_q, write_pc_q, und_q, busy_q;
  logic [1:0]         pc_s_q;

  logic [INSTR_W-1:0] mem_q [IQ_DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    count_q;
  logic               push, pop, flush;

  assign imem_ready_o = (count_q != CntW'(IQ_DEPTH));
  assign push         = imem_valid_i & imem_ready_o;
  assign pop          = (state_q == StIdle) && (count_q != '0);
  assign flush        = (state_q == StBranch);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      // Taken branch drops queued words and any word arriving this cycle.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= imem_data_i;
  end

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    case (c)
      4'h0:    return z;
      4'h1:    return !z;
      4'h2:    return cf;
      4'h3:    return !cf;
      4'h4:    return n;
      4'h5:    return !n;
      4'h6:    return v;
      4'h7:    return !v;
      4'h8:    return cf && !z;
      4'h9:    return !cf || z;
      4'hA:    return n == v;
      4'hB:    return n != v;
      4'hC:    return !z && (n == v);
      4'hD:    return z || (n != v);
      4'hE:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  logic is_dp, is_b, is_undef, cond_ok;
  assign is_dp    = (ir_q[27:26] == 2'b00);
  assign is_b     = (ir_q[27:25] == 3'b101);
  assign is_undef = (ir_q[31:28] == 4'hF) || !(is_dp || is_b);
  assign cond_ok  = cond_pass(ir_q[31:28], nzcv_i);

  // Strobes are registered alongside the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ir_q        <= '0;
      la_q        <= 1'b0;
      lb_q        <= 1'b0;
      lc_q        <= 1'b0;
      lf_q        <= 1'b0;
      write_reg_q <= 1'b0;
      write_pc_q  <= 1'b0;
      pc_s_q      <= 2'b00;
      und_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      la_q        <= 1'b0;
      lb_q        <= 1'b0;
      lc_q        <= 1'b0;
      lf_q        <= 1'b0;
      write_reg_q <= 1'b0;
      write_pc_q  <= 1'b0;
      pc_s_q      <= 2'b00;
      und_q       <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            ir_q    <= mem_q[rd_ptr_q];
            state_q <= StDecode;
            busy_q  <= 1'b1;
          end
        end
        StDecode: begin
          if (is_undef) begin
            state_q <= StUnd;
            und_q   <= 1'b1;
          end else if (!cond_ok) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (is_b) begin
            state_q    <= StBranch;
            write_pc_q <= 1'b1;
            pc_s_q     <= 2'b01;
          end else begin
            state_q <= StRead;
            la_q    <= 1'b1;
            lb_q    <= 1'b1;
          end
        end
        StRead: begin
          state_q <= StExec;
          lc_q    <= 1'b1;
          lf_q    <= ir_q[20];
        end
        StExec: begin
          state_q     <= StWb;
          // TST/TEQ/CMP/CMN (1000..1011) only set flags.
          write_reg_q <= (ir_q[24:23] != 2'b10);
        end
        StWb, StBranch, StUnd: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] retired_q, skip_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
      skip_q    <= '0;
    end else begin
      if (state_q == StWb || state_q == StBranch) retired_q <= retired_q + 32'd1;
      if (state_q == StDecode && !is_undef && !cond_ok) skip_q <= skip_q + 32'd1;
    end
  end

  assign retired_cnt_o = retired_q;
  assign skip_cnt_o    = skip_q;
`endif

  assign ir_o        = ir_q;
  assign rd_o        = REG_AW'(ir_q[15:12]);
  assign rn_o        = REG_AW'(ir_q[19:16]);
  assign rm_o        = REG_AW'(ir_q[3:0]);
  assign imm24_o     = ir_q[23:0];
  assign alu_op_o    = ir_q[24:21];
  assign write_reg_o = write_reg_q;
  assign write_pc_o  = write_pc_q;
  assign pc_s_o      = pc_s_q;
  assign la_o        = la_q;
  assign lb_o        = lb_q;
  assign lc_o        = lc_q;
  assign lf_o        = lf_q;
  assign und_ins_o   = und_q;
  assign busy_o      = busy_q;

endmodule
